// File: rtl/zombie_spawner.sv
// Three independent zombie slots (IDLE/ARM/WAIT/ACTIVE/DEAD) that spawn, walk toward the player and report damage.
// Optional macro ZOMBIE_RESPAWN_EN: a zombie reaching the player respawns at X_START instead of dying.
module zombie_spawner #(
    parameter logic [9:0] X_START  = 10'd620,
    parameter logic [9:0] X_PLAYER = 10'd40
) (
    input  logic       Clk,
    input  logic       Reset_l,
    input  logic       frame_tick,
    input  logic       new_level,
    input  logic       playing,
    input  logic [9:0] zombie_0_speed,
    input  logic [9:0] zombie_1_speed,
    input  logic [9:0] zombie_2_speed,
    input  logic [9:0] zombie_0_delay_spawn,
    input  logic [9:0] zombie_1_delay_spawn,
    input  logic [9:0] zombie_2_delay_spawn,
    input  logic [2:0] zombie_hit,
    output logic [2:0] zombie_alive,
    output logic [9:0] zombie_0_x,
    output logic [9:0] zombie_1_x,
    output logic [9:0] zombie_2_x,
    output logic       enemies,
    output logic [1:0] damage,
    output logic [8:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_WAIT   = 3'd2,
        S_ACTIVE = 3'd3,
        S_DEAD   = 3'd4
    } slot_state_t;

    logic [9:0]  w_speed_in [3];
    logic [9:0]  w_delay_in [3];

    slot_state_t r_state    [3];
    slot_state_t w_state_nxt[3];
    logic [9:0]  r_count    [3];
    logic [9:0]  w_count_nxt[3];
    logic [9:0]  r_speed    [3];
    logic [9:0]  w_speed_nxt[3];
    logic [9:0]  r_x        [3];
    logic [9:0]  w_x_nxt    [3];
    logic [9:0]  w_diff     [3];
    logic [2:0]  w_reach;
    logic [2:0]  w_reach_q;

    assign w_speed_in[0] = zombie_0_speed;
    assign w_speed_in[1] = zombie_1_speed;
    assign w_speed_in[2] = zombie_2_speed;
    assign w_delay_in[0] = zombie_0_delay_spawn;
    assign w_delay_in[1] = zombie_1_delay_spawn;
    assign w_delay_in[2] = zombie_2_delay_spawn;

    // Priority per slot: new_level, then !playing, then the normal per-state transition.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_state_nxt[i] = r_state[i];
            w_count_nxt[i] = r_count[i];
            w_speed_nxt[i] = r_speed[i];
            w_x_nxt[i]     = r_x[i];
            w_diff[i]      = r_x[i] - r_speed[i];
            w_reach[i]     = 1'b0;
            if (new_level) begin
                w_state_nxt[i] = S_ARM;
                w_count_nxt[i] = 10'd0;
                w_speed_nxt[i] = 10'd0;
                w_x_nxt[i]     = X_START;
            end else if (!playing) begin
                w_state_nxt[i] = S_IDLE;
                w_count_nxt[i] = 10'd0;
                w_speed_nxt[i] = 10'd0;
                w_x_nxt[i]     = X_START;
            end else begin
                case (r_state[i])
                    S_ARM: begin
                        w_state_nxt[i] = S_WAIT;
                        w_speed_nxt[i] = w_speed_in[i];
                        w_count_nxt[i] = w_delay_in[i];
                    end
                    S_WAIT: begin
                        if (r_count[i] == 10'd0) begin
                            w_state_nxt[i] = S_ACTIVE;
                            w_x_nxt[i]     = X_START;
                        end else if (frame_tick) begin
                            w_count_nxt[i] = r_count[i] - 10'd1;
                        end
                    end
                    S_ACTIVE: begin
                        if (zombie_hit[i]) begin
                            w_state_nxt[i] = S_DEAD;
                        end else if (frame_tick && (r_speed[i] != 10'd0)) begin
                            // x < speed would wrap, so it counts as reaching the player.
                            if ((r_x[i] < r_speed[i]) || (w_diff[i] <= X_PLAYER)) begin
                                w_reach[i] = 1'b1;
`ifdef ZOMBIE_RESPAWN_EN
                                w_x_nxt[i] = X_START;
`else
                                w_state_nxt[i] = S_DEAD;
`endif
                            end else begin
                                w_x_nxt[i] = w_diff[i];
                            end
                        end
                    end
                    default: begin
                        w_state_nxt[i] = r_state[i];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!Reset_l) begin
                r_state[i] <= S_IDLE;
                r_count[i] <= 10'd0;
                r_speed[i] <= 10'd0;
                r_x[i]     <= X_START;
            end else begin
                r_state[i] <= w_state_nxt[i];
                r_count[i] <= w_count_nxt[i];
                r_speed[i] <= w_speed_nxt[i];
                r_x[i]     <= w_x_nxt[i];
            end
        end
    end

    // Reset wins over a coincident reach in the same cycle.
    assign w_reach_q = w_reach & {3{Reset_l}};
    assign damage    = 2'(w_reach_q[0]) + 2'(w_reach_q[1]) + 2'(w_reach_q[2]);

    always_comb begin
        enemies = 1'b0;
        for (int i = 0; i < 3; i++) begin
            zombie_alive[i] = (r_state[i] == S_ACTIVE);
            if ((r_state[i] == S_ARM) || (r_state[i] == S_WAIT) || (r_state[i] == S_ACTIVE)) begin
                enemies = 1'b1;
            end
        end
    end

    assign zombie_0_x  = r_x[0];
    assign zombie_1_x  = r_x[1];
    assign zombie_2_x  = r_x[2];
    assign o_dbg_state = {r_state[2], r_state[1], r_state[0]};

endmodule

// File: tb/tb_zombie_spawner.sv
// Directed bench for zombie_spawner: a vector table for the basic spawn flow plus hand-written corner sequences.
module tb_zombie_spawner;

    logic       Clk;
    logic       Reset_l;
    logic       frame_tick;
    logic       new_level;
    logic       playing;
    logic [9:0] zombie_0_speed, zombie_1_speed, zombie_2_speed;
    logic [9:0] zombie_0_delay_spawn, zombie_1_delay_spawn, zombie_2_delay_spawn;
    logic [2:0] zombie_hit;
    logic [2:0] zombie_alive;
    logic [9:0] zombie_0_x, zombie_1_x, zombie_2_x;
    logic       enemies;
    logic [1:0] damage;
    logic [8:0] o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    zombie_spawner dut (
        .Clk                  (Clk),
        .Reset_l              (Reset_l),
        .frame_tick           (frame_tick),
        .new_level            (new_level),
        .playing              (playing),
        .zombie_0_speed       (zombie_0_speed),
        .zombie_1_speed       (zombie_1_speed),
        .zombie_2_speed       (zombie_2_speed),
        .zombie_0_delay_spawn (zombie_0_delay_spawn),
        .zombie_1_delay_spawn (zombie_1_delay_spawn),
        .zombie_2_delay_spawn (zombie_2_delay_spawn),
        .zombie_hit           (zombie_hit),
        .zombie_alive         (zombie_alive),
        .zombie_0_x           (zombie_0_x),
        .zombie_1_x           (zombie_1_x),
        .zombie_2_x           (zombie_2_x),
        .enemies              (enemies),
        .damage               (damage),
        .o_dbg_state          (o_dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       nl;
        logic       pl;
        logic       ft;
        logic [2:0] hit;
        logic [1:0] dmg;
        logic [2:0] alive;
        logic       en;
        logic [9:0] x0;
        logic [9:0] x1;
        logic [9:0] x2;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name, input logic [2:0] alive, input logic en,
                            input logic [9:0] x0, input logic [9:0] x1, input logic [9:0] x2);
        chk({name, " alive"}, 32'(zombie_alive), 32'(alive));
        chk({name, " enemies"}, 32'(enemies), 32'(en));
        chk({name, " x0"}, 32'(zombie_0_x), 32'(x0));
        chk({name, " x1"}, 32'(zombie_1_x), 32'(x1));
        chk({name, " x2"}, 32'(zombie_2_x), 32'(x2));
    endtask

    task automatic set_params(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2,
                              input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2);
        zombie_0_speed       = s0;
        zombie_1_speed       = s1;
        zombie_2_speed       = s2;
        zombie_0_delay_spawn = d0;
        zombie_1_delay_spawn = d1;
        zombie_2_delay_spawn = d2;
    endtask

    // Drive inputs one tick after a rising edge and let combinational outputs settle.
    task automatic apply(input logic nl, input logic pl, input logic ft, input logic [2:0] hit);
        new_level  = nl;
        playing    = pl;
        frame_tick = ft;
        zombie_hit = hit;
        #2;
    endtask

    task automatic edge_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_level();
        apply(1'b1, 1'b1, 1'b0, 3'b000);
        edge_step();
        apply(1'b0, 1'b1, 1'b0, 3'b000);
        edge_step();
        apply(1'b0, 1'b1, 1'b0, 3'b000);
        edge_step();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            apply(1'b0, 1'b1, 1'b1, 3'b000);
            chk("walk dmg", 32'(damage), 32'd0);
            edge_step();
        end
    endtask

    initial begin
        // Speeds 1/1/1, delays 2/0/5: slot1 spawns first, slot0 after 2 ticks, slot2 after 5.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 10'd620, 10'd620, 10'd620};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 10'd620, 10'd620, 10'd620};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 3'b010, 1'b1, 10'd620, 10'd620, 10'd620};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 3'b010, 1'b1, 10'd620, 10'd619, 10'd620};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 3'b010, 1'b1, 10'd620, 10'd618, 10'd620};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 3'b011, 1'b1, 10'd620, 10'd618, 10'd620};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 3'b011, 1'b1, 10'd619, 10'd617, 10'd620};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 3'b011, 1'b1, 10'd618, 10'd616, 10'd620};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 3'b011, 1'b1, 10'd617, 10'd615, 10'd620};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 3'b111, 1'b1, 10'd617, 10'd615, 10'd620};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 3'b010, 2'd0, 3'b101, 1'b1, 10'd616, 10'd615, 10'd619};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 3'b010, 2'd0, 3'b101, 1'b1, 10'd616, 10'd615, 10'd619};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b0, 10'd620, 10'd620, 10'd620};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 3'b111, 2'd0, 3'b000, 1'b0, 10'd620, 10'd620, 10'd620};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 10'd620, 10'd620, 10'd620};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b0, 10'd620, 10'd620, 10'd620};

        Reset_l = 1'b0;
        set_params(10'd1, 10'd1, 10'd1, 10'd2, 10'd0, 10'd5);
        apply(1'b0, 1'b0, 1'b0, 3'b000);
        edge_step();
        edge_step();
        chk_regs("reset", 3'b000, 1'b0, 10'd620, 10'd620, 10'd620);
        chk("reset dmg", 32'(damage), 32'd0);
        chk("reset state", 32'(o_dbg_state), 32'd0);
        Reset_l = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].nl, tbl[i].pl, tbl[i].ft, tbl[i].hit);
            chk($sformatf("vec%0d dmg", i), 32'(damage), 32'(tbl[i].dmg));
            edge_step();
            chk_regs($sformatf("vec%0d", i), tbl[i].alive, tbl[i].en, tbl[i].x0, tbl[i].x1, tbl[i].x2);
        end

        // Slot0 at speed 100 walks 620 -> 120, then the next tick reaches the player.
        // Slots 1 and 2 at speed 0 never move.
        set_params(10'd100, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        start_level();
        chk_regs("walk spawn", 3'b111, 1'b1, 10'd620, 10'd620, 10'd620);
        for (int k = 1; k <= 5; k++) begin
            apply(1'b0, 1'b1, 1'b1, 3'b000);
            chk("walk dmg", 32'(damage), 32'd0);
            edge_step();
            chk("walk x0", 32'(zombie_0_x), 32'(620 - 100 * k));
        end
        apply(1'b0, 1'b1, 1'b1, 3'b000);
        chk("reach dmg", 32'(damage), 32'd1);
        edge_step();
`ifdef ZOMBIE_RESPAWN_EN
        chk_regs("reach", 3'b111, 1'b1, 10'd620, 10'd620, 10'd620);
`else
        chk_regs("reach", 3'b110, 1'b1, 10'd120, 10'd620, 10'd620);
`endif
        apply(1'b0, 1'b1, 1'b1, 3'b000);
        chk("post reach dmg", 32'(damage), 32'd0);
        edge_step();

        // Hit on all three coinciding with the reaching tick: hit wins.
        set_params(10'd100, 10'd100, 10'd100, 10'd0, 10'd0, 10'd0);
        start_level();
        ticks(5);
        chk_regs("near", 3'b111, 1'b1, 10'd120, 10'd120, 10'd120);
        apply(1'b0, 1'b1, 1'b1, 3'b111);
        chk("hit wins dmg", 32'(damage), 32'd0);
        edge_step();
        chk_regs("hit all", 3'b000, 1'b0, 10'd120, 10'd120, 10'd120);

        // All three reach the player in the same cycle.
        start_level();
        ticks(5);
        apply(1'b0, 1'b1, 1'b1, 3'b000);
        chk("triple dmg", 32'(damage), 32'd3);
        edge_step();
`ifdef ZOMBIE_RESPAWN_EN
        chk_regs("triple", 3'b111, 1'b1, 10'd620, 10'd620, 10'd620);
`else
        chk_regs("triple", 3'b000, 1'b0, 10'd120, 10'd120, 10'd120);
`endif

        // Speed larger than x must not wrap: reached on the very first tick.
        set_params(10'd700, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        start_level();
        apply(1'b0, 1'b1, 1'b1, 3'b000);
        chk("wrap dmg", 32'(damage), 32'd1);
        edge_step();
`ifdef ZOMBIE_RESPAWN_EN
        chk_regs("wrap", 3'b111, 1'b1, 10'd620, 10'd620, 10'd620);
`else
        chk_regs("wrap", 3'b110, 1'b1, 10'd620, 10'd620, 10'd620);
`endif

        // new_level mid-walk rearms everything; parameters are sampled in the ARM cycle, not before.
        set_params(10'd80, 10'd80, 10'd80, 10'd0, 10'd0, 10'd0);
        start_level();
        ticks(4);
        chk_regs("at 300", 3'b111, 1'b1, 10'd300, 10'd300, 10'd300);
        set_params(10'd50, 10'd50, 10'd50, 10'd1, 10'd1, 10'd1);
        apply(1'b1, 1'b1, 1'b1, 3'b000);
        chk("relevel dmg", 32'(damage), 32'd0);
        edge_step();
        chk_regs("rearm", 3'b000, 1'b1, 10'd620, 10'd620, 10'd620);
        chk("rearm state", 32'(o_dbg_state), 32'h49);
        set_params(10'd60, 10'd60, 10'd60, 10'd1, 10'd1, 10'd1);
        apply(1'b0, 1'b1, 1'b0, 3'b000);
        edge_step();
        apply(1'b0, 1'b1, 1'b1, 3'b000);
        edge_step();
        chk_regs("relevel wait", 3'b000, 1'b1, 10'd620, 10'd620, 10'd620);
        apply(1'b0, 1'b1, 1'b0, 3'b000);
        edge_step();
        chk_regs("relevel spawn", 3'b111, 1'b1, 10'd620, 10'd620, 10'd620);
        apply(1'b0, 1'b1, 1'b1, 3'b000);
        edge_step();
        chk_regs("relevel speed", 3'b111, 1'b1, 10'd560, 10'd560, 10'd560);

        // Reset with new_level, hit and tick all high: reset wins.
        set_params(10'd100, 10'd0, 10'd0, 10'd0, 10'd5, 10'd5);
        start_level();
        apply(1'b0, 1'b1, 1'b1, 3'b000);
        edge_step();
        chk_regs("pre reset", 3'b001, 1'b1, 10'd520, 10'd620, 10'd620);
        Reset_l = 1'b0;
        apply(1'b1, 1'b1, 1'b1, 3'b111);
        chk("reset cycle dmg", 32'(damage), 32'd0);
        edge_step();
        chk_regs("mid reset", 3'b000, 1'b0, 10'd620, 10'd620, 10'd620);
        chk("mid reset dmg", 32'(damage), 32'd0);
        chk("mid reset state", 32'(o_dbg_state), 32'd0);
        Reset_l = 1'b1;
        apply(1'b0, 1'b1, 1'b1, 3'b000);
        edge_step();
        chk_regs("idle holds", 3'b000, 1'b0, 10'd620, 10'd620, 10'd620);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
